// File: rtl/uart_fir_pkg.sv
// Shared definitions for the UART <-> FIR link controller:
// byte width, TX sequencer state encoding, and a counter-width helper.
package uart_fir_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } tx_state_e;

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_sample_assembler.sv
// Collects UART bytes MSB-first into IN_W-bit samples and emits a
// one-cycle strobe with the finished sample, which is held until the next.
module uart_sample_assembler
    import uart_fir_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [7:0]      i_byte,
    input  logic            i_byte_vld,
    output logic [IN_W-1:0] o_sample,
    output logic            o_sample_vld
);

    localparam int NBYTES = IN_W / BYTE_W;
    localparam int CNT_W  = cnt_w(NBYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    logic [IN_W-1:0]  r_asm;
    logic [CNT_W-1:0] r_cnt;
    logic [IN_W-1:0]  r_sample;
    logic             r_sample_vld;
    logic [IN_W-1:0]  w_asm_nxt;

    // Earlier bytes move up; the newest byte always lands in the low byte.
    always_comb begin
        w_asm_nxt = (r_asm << BYTE_W) | IN_W'(i_byte);
    end

    // Byte counting, sample capture on the last byte, single-cycle strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_asm        <= '0;
            r_cnt        <= '0;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_sample_vld <= 1'b0;
            if (i_byte_vld) begin
                r_asm <= w_asm_nxt;
                if (r_cnt == LAST) begin
                    r_cnt        <= '0;
                    r_sample     <= w_asm_nxt;
                    r_sample_vld <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_sample     = r_sample;
    assign o_sample_vld = r_sample_vld;

endmodule

// File: rtl/uart_fir_link_ctrl.sv
// UART <-> FIR link controller.
// RX: bytes are assembled into FIR input samples (uart_sample_assembler).
// TX: FIR results go through a one-entry pending buffer into a shift
//     register and are sent MSB byte first, handshaking on tx_busy.
// Optional: UART_CTRL_OVERRUN_EN adds a sticky overrun flag for results
//     dropped because the pending buffer was full; otherwise overrun is 0.
module uart_fir_link_ctrl
    import uart_fir_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [IN_W-1:0]  fir_in_data,
    output logic             fir_in_valid,
    input  logic [OUT_W-1:0] fir_out_data,
    input  logic             fir_out_valid,
    output logic             overrun
);

    localparam int NB_OUT = OUT_W / BYTE_W;
    localparam int TCW    = cnt_w(NB_OUT);
    localparam logic [TCW-1:0] TX_LAST = TCW'(NB_OUT - 1);

    // ---------------- RX side ----------------
    uart_sample_assembler #(
        .IN_W (IN_W)
    ) u_asm (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_byte       (rx_data),
        .i_byte_vld   (rx_ready),
        .o_sample     (fir_in_data),
        .o_sample_vld (fir_in_valid)
    );

    // ---------------- TX side ----------------
    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic [OUT_W-1:0] r_pend_data;
    logic             r_pend_full;
    logic [OUT_W-1:0] r_shift;
    logic [TCW-1:0]   r_tx_cnt;
    logic             r_hi_cnt;

    logic w_drain;
    logic w_load;
    logic w_shift_en;
    logic w_last;
    logic w_tx_start;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state. START holds while busy so a start never overlaps busy;
    // WAIT_HI re-issues the byte if busy never shows up within two cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (r_pend_full && !tx_busy) w_state_nxt = ST_START;
            ST_START:   if (!tx_busy) w_state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (tx_busy)       w_state_nxt = ST_WAIT_LO;
                else if (r_hi_cnt) w_state_nxt = ST_START;
            end
            ST_WAIT_LO: begin
                if (!tx_busy) w_state_nxt = w_last ? ST_IDLE : ST_START;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath controls.
    always_comb begin
        w_last     = (r_tx_cnt == TX_LAST);
        w_drain    = (r_state == ST_IDLE)    && r_pend_full && !tx_busy;
        w_tx_start = (r_state == ST_START)   && !tx_busy;
        w_shift_en = (r_state == ST_WAIT_LO) && !tx_busy;
        w_load     = fir_out_valid && (!r_pend_full || w_drain);
    end

    // Pending buffer: accepts a result when empty or emptying this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_data <= '0;
            r_pend_full <= 1'b0;
        end else if (w_load) begin
            r_pend_data <= fir_out_data;
            r_pend_full <= 1'b1;
        end else if (w_drain) begin
            r_pend_full <= 1'b0;
        end
    end

    // Shift register and byte counter; shifts only once busy has dropped,
    // so tx_data is stable for the whole busy window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift  <= '0;
            r_tx_cnt <= '0;
        end else if (w_drain) begin
            r_shift  <= r_pend_data;
            r_tx_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift <= r_shift << BYTE_W;
            if (!w_last) r_tx_cnt <= r_tx_cnt + TCW'(1);
        end
    end

    // Counts busy-less cycles spent in WAIT_HI.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_hi_cnt <= 1'b0;
        else      r_hi_cnt <= (r_state == ST_WAIT_HI) && !tx_busy && !r_hi_cnt;
    end

    assign tx_start = w_tx_start;
    assign tx_data  = r_shift[OUT_W-1 -: BYTE_W];

`ifdef UART_CTRL_OVERRUN_EN
    logic r_overrun;
    logic w_drop;

    // Sticky flag for results lost to a full, non-draining pending buffer.
    always_comb begin
        w_drop = fir_out_valid && r_pend_full && !w_drain;
    end

    // Overrun flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_overrun <= 1'b0;
        else if (w_drop) r_overrun <= 1'b1;
    end

    assign overrun = r_overrun;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fir_link_ctrl.sv
// Scoreboard bench for uart_fir_link_ctrl (IN_W = OUT_W = 16).
// Stimulus pushes expected samples/bytes; a negedge monitor pops and
// compares whenever fir_in_valid or tx_start is seen.
module tb_uart_fir_link_ctrl;

`ifdef UART_CTRL_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] fir_in_data;
    logic        fir_in_valid;
    logic [15:0] fir_out_data;
    logic        fir_out_valid;
    logic        overrun;

    always #5 clk = ~clk;

    uart_fir_link_ctrl #(.IN_W(16), .OUT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .fir_in_data   (fir_in_data),
        .fir_in_valid  (fir_in_valid),
        .fir_out_data  (fir_out_data),
        .fir_out_valid (fir_out_valid),
        .overrun       (overrun)
    );

    // UART transmitter model: busy for 10 cycles after each accepted start.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    logic [15:0] rx_q[$];
    logic [7:0]  tx_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        prev_fin = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_start) begin
                check("tx_start_while_busy", 32'(tx_busy), 32'd0);
                if (tx_q.size() == 0) check("tx_unexpected_start", 32'(tx_data), 32'hFFFF_FFFF);
                else                  check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
            end
            if (fir_in_valid) begin
                check("fir_in_valid_one_cycle", 32'(prev_fin), 32'd0);
                if (rx_q.size() == 0) check("fir_in_unexpected", 32'(fir_in_data), 32'hFFFF_FFFF);
                else                  check("fir_in_data", 32'(fir_in_data), 32'(rx_q.pop_front()));
            end
        end
        prev_fin <= fir_in_valid;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
    endtask

    task automatic send_fir(input logic [15:0] d);
        fir_out_data  = d;
        fir_out_valid = 1'b1;
        cyc();
        fir_out_valid = 1'b0;
    endtask

    task automatic wait_tx_idle(input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || tx_busy) && n < budget) begin
            cyc();
            n++;
        end
        check("tx_drain_timeout", 32'(n >= budget), 32'd0);
        repeat (3) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] hi;
        int         k;
        int         n;
        rst           = 1'b0;
        rx_data       = '0;
        rx_ready      = 1'b0;
        fir_out_data  = '0;
        fir_out_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start",     32'(tx_start),     32'd0);
        check("rst_tx_data",      32'(tx_data),      32'd0);
        check("rst_fir_in_valid", 32'(fir_in_valid), 32'd0);
        check("rst_fir_in_data",  32'(fir_in_data),  32'd0);
        check("rst_overrun",      32'(overrun),      32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc();

        // 0x12, 0x34 -> 0x1234 strobed the cycle after the second byte
        rx_q.push_back(16'h1234);
        send_rx(8'h12);
        send_rx(8'h34);
        @(negedge clk);
        check("fin_valid_timing", 32'(fir_in_valid), 32'd1);
        @(negedge clk);
        check("fin_valid_drop",   32'(fir_in_valid), 32'd0);
        check("fin_data_stable",  32'(fir_in_data),  32'h1234);
        cyc();

        // Bytes with idle gaps between them
        rx_q.push_back(16'hBEEF);
        send_rx(8'hBE);
        repeat (3) cyc();
        send_rx(8'hEF);
        repeat (2) cyc();

        // 0xABCD: two bytes MSB first, tx_start two cycles after the strobe
        tx_q.push_back(8'hAB);
        tx_q.push_back(8'hCD);
        fir_out_data  = 16'hABCD;
        fir_out_valid = 1'b1;
        cyc();
        fir_out_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("tx_latency", 32'(tx_start), 32'd1);
        #1;
        wait_tx_idle(100);

        // Three back-to-back results: first two sent, third dropped
        tx_q.push_back(8'h11); tx_q.push_back(8'h11);
        tx_q.push_back(8'h22); tx_q.push_back(8'h22);
        send_fir(16'h1111);
        send_fir(16'h2222);
        send_fir(16'h3333);
        @(negedge clk);
        check("overrun_on_drop", 32'(overrun), 32'(EXP_OVR));
        #1;
        wait_tx_idle(200);
        check("overrun_sticky", 32'(overrun), 32'(EXP_OVR));

        // Reset mid-sample discards the partial byte
        rx_q.push_back(16'h5678);
        send_rx(8'h99);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_fin_data", 32'(fir_in_data), 32'd0);
        check("rst_clears_ovr",   32'(overrun),     32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        send_rx(8'h56);
        send_rx(8'h78);
        repeat (2) cyc();

        // Reset during WAIT_LO: frame abandoned after its first byte
        tx_q.push_back(8'hA1);
        send_fir(16'hA1B2);
        n = 0;
        while (!tx_start && n < 10) begin
            cyc();
            n++;
        end
        check("tx_start_seen", 32'(n < 10), 32'd1);
        repeat (4) cyc();
        #2 rst = 1'b0;
        #1;
        check("rst_wlo_tx_start", 32'(tx_start), 32'd0);
        check("rst_wlo_tx_data",  32'(tx_data),  32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'hD4);
        send_fir(16'hC3D4);
        wait_tx_idle(200);

        // Concurrent RX bytes every cycle with periodic FIR results
        k = 0;
        hi = '0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 30; j++) begin
                rx_data  = 8'(i * 30 + j + 5);
                rx_ready = 1'b1;
                if (k % 2 == 0) hi = rx_data;
                else            rx_q.push_back({hi, rx_data});
                k++;
                if (j == 0) begin
                    fir_out_data  = {8'(8'h10 + i), 8'(8'h80 + i)};
                    fir_out_valid = 1'b1;
                    tx_q.push_back(8'(8'h10 + i));
                    tx_q.push_back(8'(8'h80 + i));
                end
                cyc();
                fir_out_valid = 1'b0;
            end
        end
        rx_ready = 1'b0;
        wait_tx_idle(200);

        repeat (3) cyc();
        check("rx_q_empty", 32'(rx_q.size()), 32'd0);
        check("tx_q_empty", 32'(tx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
